// File: rtl/lmc_pkg.sv
// Shared definitions for the LMC sequencer: the opcode map, the IO sub-codes and the FSM state encoding.
package lmc_pkg;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h5;
    localparam logic [3:0] OP_BRA = 4'h6;
    localparam logic [3:0] OP_BRZ = 4'h7;
    localparam logic [3:0] OP_BRP = 4'h8;
    localparam logic [3:0] OP_IO  = 4'h9;

    localparam logic [3:0] IO_INP = 4'h1;
    localparam logic [3:0] IO_OUT = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_WAIT_OUT = 3'd5,
        ST_HALT     = 3'd6
    } state_t;

    // HLT is legal here; the caller routes it to HALT separately without flagging it as illegal.
    function automatic logic opcode_legal(input logic [3:0] op, input logic io_sub_ok);
        logic ok;
        case (op)
            OP_HLT, OP_ADD, OP_SUB, OP_STA, OP_LDA,
            OP_BRA, OP_BRZ, OP_BRP: ok = 1'b1;
            OP_IO:                  ok = io_sub_ok;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lmc_alu.sv
// Accumulator adder/subtractor for the LMC sequencer.
// The result wraps modulo 2**M. The borrow output is valid only for subtraction.
module lmc_alu #(
    parameter int M = 8
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         sub,
    output logic [M-1:0] result,
    output logic         borrow
);

    logic [M:0] wide;

    always_comb begin
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = wide[M-1:0];
    assign borrow = sub & wide[M];

endmodule

// File: rtl/lmc_sequencer.sv
// LMC fetch/decode/execute controller.
// It owns pc, ir and acc, and it drives the shared async-read/sync-write program RAM and the front-panel IO handshakes.
//
// state    | meaning
// IDLE     | stopped; pc_load may preset pc, run starts fetching
// FETCH    | ir <= RAM[pc], pc advances
// DECODE   | operand address presented; HLT/undefined opcodes go to HALT
// EXEC     | ALU/load/store/branch; IO instructions branch to a wait state
// WAIT_IN  | in_ready high until in_valid delivers a value into acc
// WAIT_OUT | out_valid high with acc snapshot until out_ready
// HALT     | terminal until reset_n
module lmc_sequencer
    import lmc_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 8
) (
    input  logic         timer555,
    input  logic         reset_n,
    input  logic         run,
    input  logic         pc_load,
    output logic [N-1:0] mem_adr,
    output logic [M-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [M-1:0] mem_rdata,
    input  logic [M-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [M-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pc,
    output logic [M-1:0] acc,
    output logic         halted,
    output logic         illegal
);

    state_t       state;
    state_t       resume;
    logic [M-1:0] ir;
    logic         neg;
    logic [3:0]   opcode;
    logic [N-1:0] operand;
    logic         io_inp;
    logic         io_out;
    logic         legal;
    logic         alu_sub;
    logic [M-1:0] alu_result;
    logic         alu_borrow;

    assign opcode  = ir[M-1:N];
    assign operand = ir[N-1:0];
    assign io_inp  = (operand == N'(IO_INP));
    assign io_out  = (operand == N'(IO_OUT));
    assign legal   = opcode_legal(opcode, io_inp | io_out);
    assign resume  = run ? ST_FETCH : ST_IDLE;
    assign alu_sub = (opcode == OP_SUB);

    lmc_alu #(.M(M)) u_alu (
        .a      (acc),
        .b      (mem_rdata),
        .sub    (alu_sub),
        .result (alu_result),
        .borrow (alu_borrow)
    );

    always_comb begin
        mem_adr = pc;
        if (state == ST_DECODE || state == ST_EXEC) begin
            mem_adr = operand;
        end
    end

    // The write strobe is decoded from the state register. An async reset therefore removes it at once.
    assign mem_we    = (state == ST_EXEC) && (opcode == OP_STA);
    assign mem_wdata = acc;

    always_ff @(posedge timer555 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_load) begin
                        pc <= in_data[N-1:0];
                    end else if (run) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + N'(1);
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (opcode == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (!legal) begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                        state   <= ST_HALT;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= resume;
                    case (opcode)
                        OP_ADD: begin
                            acc <= alu_result;
                            neg <= 1'b0;
                        end
                        OP_SUB: begin
                            acc <= alu_result;
                            neg <= alu_borrow;
                        end
                        OP_LDA: begin
                            acc <= mem_rdata;
                            neg <= 1'b0;
                        end
                        OP_BRA: pc <= operand;
                        OP_BRZ: if (acc == '0) pc <= operand;
                        OP_BRP: if (!neg) pc <= operand;
                        OP_IO: begin
                            if (io_inp) begin
                                in_ready <= 1'b1;
                                state    <= ST_WAIT_IN;
                            end else begin
                                out_data  <= acc;
                                out_valid <= 1'b1;
                                state     <= ST_WAIT_OUT;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        acc      <= in_data;
                        neg      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= resume;
                    end
                end
                ST_WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= resume;
                    end
                end
                ST_HALT: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lmc_sequencer.sv
// Scoreboard bench for lmc_sequencer.
// An instruction-level LMC model predicts stores, IO transfers and the halt point; a monitor checks the DUT against that prediction.
module tb_lmc_sequencer;

    localparam int N = 4;
    localparam int M = 8;
    localparam int EV_STORE = 0;
    localparam int EV_IN    = 1;
    localparam int EV_OUT   = 2;
    localparam int EV_HALT  = 3;

    typedef struct {
        int kind;
        int a;
        int d;
        int ill;
    } ev_t;

    logic         timer555 = 1'b0;
    logic         reset_n  = 1'b0;
    logic         run      = 1'b0;
    logic         pc_load  = 1'b0;
    logic [N-1:0] mem_adr;
    logic [M-1:0] mem_wdata;
    logic         mem_we;
    logic [M-1:0] mem_rdata;
    logic [M-1:0] in_data  = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [M-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] pc;
    logic [M-1:0] acc;
    logic         halted;
    logic         illegal;

    lmc_sequencer #(.N(N), .M(M)) dut (
        .timer555  (timer555),
        .reset_n   (reset_n),
        .run       (run),
        .pc_load   (pc_load),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc        (pc),
        .acc       (acc),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 timer555 = ~timer555;

    logic [7:0] ram [16];
    logic [7:0] img [16];
    logic       load_req = 1'b0;

    assign mem_rdata = ram[mem_adr];

    always @(posedge timer555) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) ram[i] <= img[i];
        end else if (mem_we) begin
            ram[mem_adr] <= mem_wdata;
        end
    end

    ev_t  exp_q[$];
    int   inputs[$];
    int   model_mem [16];
    bit   model_ok;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sb_rd    = 0;
    int   we_cycles = 0;
    bit   mon_en   = 0;
    bit   drv_rnd  = 0;
    bit   man_valid = 0;
    bit   man_ready = 0;
    int   man_data  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int a, input int d, input int ill);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        e.ill  = ill;
        exp_q.push_back(e);
    endtask

    // Instruction-level reference: one loop iteration per LMC instruction.
    task automatic model(input int start_pc);
        int mm [16];
        int p, a, ng, steps, op, opd, ins, k;
        bit done;
        exp_q.delete();
        for (int i = 0; i < 16; i++) mm[i] = int'(img[i]);
        p = start_pc; a = 0; ng = 0; steps = 0; k = 0; done = 0;
        while (!done && steps < 60) begin
            ins = mm[p];
            p   = (p + 1) % 16;
            op  = ins / 16;
            opd = ins % 16;
            steps++;
            case (op)
                0: begin done = 1; push_ev(EV_HALT, p, a, 0); end
                1: begin a = (a + mm[opd]) % 256; ng = 0; end
                2: begin ng = (a < mm[opd]) ? 1 : 0; a = (a - mm[opd] + 256) % 256; end
                3: begin mm[opd] = a; push_ev(EV_STORE, opd, a, 0); end
                5: begin a = mm[opd]; ng = 0; end
                6: p = opd;
                7: if (a == 0) p = opd;
                8: if (ng == 0) p = opd;
                9: begin
                    if (opd == 1) begin
                        if (k < inputs.size()) a = inputs[k];
                        k++;
                        ng = 0;
                        push_ev(EV_IN, 0, 0, 0);
                    end else if (opd == 2) begin
                        push_ev(EV_OUT, 0, a, 0);
                    end else begin
                        done = 1;
                        push_ev(EV_HALT, p, a, 1);
                    end
                end
                default: begin done = 1; push_ev(EV_HALT, p, a, 1); end
            endcase
        end
        model_ok = done && (k <= inputs.size());
        for (int i = 0; i < 16; i++) model_mem[i] = mm[i];
    endtask

    task automatic got(input int kind, input int a, input int d, input int ill);
        ev_t e;
        if (sb_rd >= exp_q.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got event kind %0d, expected no further event", kind);
        end else begin
            e = exp_q[sb_rd];
            sb_rd++;
            check("sb_kind", kind, e.kind);
            if (kind == e.kind) begin
                case (kind)
                    EV_STORE: begin
                        check("store_adr", a, e.a);
                        check("store_data", d, e.d);
                    end
                    EV_OUT: check("out_data", d, e.d);
                    EV_HALT: begin
                        check("halt_pc", a, e.a);
                        check("halt_acc", d, e.d);
                        check("halt_illegal", ill, e.ill);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin : monitor
        logic halted_q;
        halted_q = 1'b0;
        forever begin
            @(negedge timer555);
            if (!mon_en) sb_rd = 0;
            if (reset_n && mem_we) we_cycles++;
            if (mon_en && reset_n) begin
                if (mem_we) got(EV_STORE, int'(mem_adr), int'(mem_wdata), 0);
                if (in_ready && in_valid) got(EV_IN, 0, 0, 0);
                if (out_valid && out_ready) got(EV_OUT, 0, int'(out_data), 0);
                if (halted && !halted_q) got(EV_HALT, int'(pc), int'(acc), int'(illegal));
            end
            halted_q = halted;
        end
    end

    initial begin : driver
        bit take;
        int idx;
        idx = 0;
        forever begin
            @(negedge timer555);
            take = in_valid && in_ready;
            @(posedge timer555);
            #1;
            if (!drv_rnd) begin
                idx       = 0;
                in_valid  = man_valid;
                in_data   = 8'(man_data);
                out_ready = man_ready;
            end else begin
                if (take) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else if (!in_valid && idx < inputs.size() && $urandom_range(0, 2) == 0) begin
                    in_data  = 8'(inputs[idx]);
                    idx++;
                    in_valid = 1'b1;
                end
                out_ready = ($urandom_range(0, 2) == 0);
            end
        end
    end

    task automatic start_prog(input int start_pc, input bit rnd);
        mon_en = 0; drv_rnd = 0; man_valid = 0; man_ready = 0; man_data = 0;
        run = 1'b0; pc_load = 1'b0;
        @(posedge timer555); #1;
        reset_n  = 1'b0;
        load_req = 1'b1;
        model(start_pc);
        @(posedge timer555); #1;
        load_req = 1'b0;
        reset_n  = 1'b1;
        if (start_pc != 0) begin
            man_data = start_pc;
            pc_load  = 1'b1;
            repeat (2) @(posedge timer555);
            #1;
            pc_load = 1'b0;
            check("pc_load", int'(pc), start_pc);
        end
        mon_en  = 1;
        drv_rnd = rnd;
    endtask

    task automatic finish_prog(output int cyc);
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(posedge timer555); #1;
            cyc++;
        end
        check("halt_reached", int'(halted), 1);
        @(negedge timer555);
        @(posedge timer555); #1;
        check("sb_drained", sb_rd, exp_q.size());
        for (int i = 0; i < 16; i++) check("ram_final", int'(ram[i]), model_mem[i]);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
        inputs.delete();
    endtask

    task automatic gen_prog();
        int r, op, opd;
        for (int i = 0; i < 16; i++) begin
            r   = $urandom_range(0, 99);
            opd = $urandom_range(0, 15);
            if (r < 8)       op = 0;
            else if (r < 22) op = 1;
            else if (r < 32) op = 2;
            else if (r < 44) op = 3;
            else if (r < 58) op = 5;
            else if (r < 64) op = 6;
            else if (r < 70) op = 7;
            else if (r < 76) op = 8;
            else if (r < 84) begin op = 9; opd = 1; end
            else if (r < 92) begin op = 9; opd = 2; end
            else if (r == 92) op = 4;
            else if (r == 93) op = $urandom_range(10, 15);
            else if (r == 94) begin op = 9; opd = 0; end
            else op = $urandom_range(0, 15);
            img[i] = 8'(op * 16 + opd);
        end
        inputs.delete();
        for (int i = 0; i < 64; i++) inputs.push_back($urandom_range(0, 255));
    endtask

    initial begin : main
        int cyc, we0, waited;

        // Program 1: LDA 5; ADD 2; HLT. It halts after 9 clock edges with pc=3.
        clear_img();
        img[0] = 8'h55; img[1] = 8'h12; img[2] = 8'h00; img[5] = 8'h07;
        start_prog(0, 0);
        check("rst_pc", int'(pc), 0);
        check("rst_acc", int'(acc), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_mem_we", int'(mem_we), 0);
        run = 1'b1;
        finish_prog(cyc);
        check("t1_cycles", cyc, 9);

        // run is dropped during FETCH: the instruction completes, then the sequencer idles.
        start_prog(0, 0);
        run = 1'b1;
        @(posedge timer555); #1;
        run = 1'b0;
        repeat (6) @(posedge timer555);
        #1;
        check("pause_pc", int'(pc), 1);
        check("pause_acc", int'(acc), 7);
        check("pause_halted", int'(halted), 0);
        run = 1'b1;
        finish_prog(cyc);

        // SUB borrows, so the following BRP is not taken.
        clear_img();
        img[0] = 8'h54; img[1] = 8'h25; img[2] = 8'h80; img[3] = 8'h00;
        img[4] = 8'h03; img[5] = 8'h05;
        start_prog(0, 0);
        run = 1'b1;
        finish_prog(cyc);
        check("sub_acc", int'(acc), 8'hFE);

        // INP 0xA5, then STA 6: exactly one write strobe.
        clear_img();
        img[0] = 8'h91; img[1] = 8'h36; img[2] = 8'h00;
        inputs.push_back(8'hA5);
        we0 = we_cycles;
        start_prog(0, 1);
        run = 1'b1;
        finish_prog(cyc);
        check("sta_we_cycles", we_cycles - we0, 1);

        // INP while in_valid stays low: in_ready must hold, and exactly one consume must happen.
        clear_img();
        img[0] = 8'h91; img[1] = 8'h00;
        inputs.push_back(8'h3C);
        start_prog(0, 0);
        run = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge timer555); #1;
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge timer555); #1;
            check("inp_ready_held", int'(in_ready), 1);
        end
        man_valid = 1; man_data = 8'h3C;
        repeat (4) @(posedge timer555);
        #1;
        man_valid = 0;
        finish_prog(cyc);
        check("inp_acc", int'(acc), 8'h3C);

        // Start at pc=15 (the fetch wraps pc to 0), then OUT while out_ready is held low.
        clear_img();
        img[15] = 8'h5E; img[14] = 8'h77; img[0] = 8'h92; img[1] = 8'h00;
        start_prog(15, 0);
        run = 1'b1;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge timer555); #1;
            waited++;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge timer555); #1;
            check("out_valid_held", int'(out_valid), 1);
            check("out_data_stable", int'(out_data), 8'h77);
        end
        man_ready = 1;
        finish_prog(cyc);

        // Async reset during the STA execute cycle: the strobe drops at once and no write lands.
        clear_img();
        img[0] = 8'h57; img[1] = 8'h36; img[6] = 8'h11; img[7] = 8'h99;
        start_prog(0, 0);
        mon_en = 0;
        run = 1'b1;
        waited = 0;
        do begin
            @(negedge timer555);
            waited++;
        end while (!mem_we && waited < 20);
        check("sta_we_seen", int'(mem_we), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_mem_we", int'(mem_we), 0);
        check("arst_pc", int'(pc), 0);
        check("arst_acc", int'(acc), 0);
        check("arst_halted", int'(halted), 0);
        check("arst_illegal", int'(illegal), 0);
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_in_ready", int'(in_ready), 0);
        @(posedge timer555); #1;
        check("arst_no_write", int'(ram[6]), 8'h11);
        run = 1'b0;
        reset_n = 1'b1;

        // An undefined opcode halts with illegal set; run is then ignored.
        clear_img();
        img[0] = 8'hF0;
        start_prog(0, 0);
        run = 1'b1;
        finish_prog(cyc);
        run = 1'b0;
        repeat (3) @(posedge timer555);
        run = 1'b1;
        repeat (5) @(posedge timer555);
        #1;
        check("halt_sticky", int'(halted), 1);
        check("illegal_sticky", int'(illegal), 1);
        check("halt_pc_frozen", int'(pc), 1);

        // Random programs, keeping only those the model shows to terminate.
        for (int t = 0; t < 30; t++) begin
            int tries;
            tries = 0;
            do begin
                gen_prog();
                model(0);
                tries++;
            end while (!model_ok && tries < 500);
            if (model_ok) begin
                start_prog(0, 1);
                run = 1'b1;
                finish_prog(cyc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
